proc_control_fsm: RTL and testbench

Multi-cycle control unit for the simple processor. It consumes the 10-bit instruction words (`FuncOUT`) produced by the ROM integration stage and latches each word into an instruction register. It then sequences the register file, the A/G registers, the ALU and the bus multiplexer through time steps T0–T3, and signals `Done` when each instruction retires.

---
 rtl/proc_control_fsm_pkg.sv | 43 ++++
 rtl/proc_control_fsm_dec3to8.sv | 16 +
 rtl/proc_control_fsm_regn.sv | 22 ++
 rtl/proc_control_fsm.sv | 168 ++++++++++++++++
 tb/tb_proc_control_fsm.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/proc_control_fsm_pkg.sv
// proc_defs: shared definitions for the processor control unit.
//   - opcode constants for the 4-bit opcode field
//   - 2-bit time-step encoding T0..T3
//   - ALU operation codes driven on AluOp
//   - instruction register field widths
//   - alu_op_of(): maps an ALU opcode onto its AluOp code
package proc_defs;

  localparam int IR_W  = 10;
  localparam int OPC_W = 4;
  localparam int REG_W = 3;

  localparam logic [OPC_W-1:0] OP_MV  = 4'b0000;
  localparam logic [OPC_W-1:0] OP_MVI = 4'b0001;
  localparam logic [OPC_W-1:0] OP_ADD = 4'b0010;
  localparam logic [OPC_W-1:0] OP_SUB = 4'b0011;
  localparam logic [OPC_W-1:0] OP_AND = 4'b0100;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  // Non-ALU opcodes never reach T2, so their mapping is irrelevant.
  function automatic logic [1:0] alu_op_of(input logic [OPC_W-1:0] op);
    case (op)
      OP_SUB:  alu_op_of = ALU_SUB;
      OP_AND:  alu_op_of = ALU_AND;
      default: alu_op_of = ALU_ADD;
    endcase
  endfunction

  function automatic logic is_alu_op(input logic [OPC_W-1:0] op);
    is_alu_op = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
  endfunction

endpackage

// File: rtl/proc_control_fsm_dec3to8.sv
// dec3to8: 3-to-8 one-hot decoder with enable.
//   en  : when low, the output is all zeros
//   sel : index of the bit to set
//   y   : one-hot result (at most one bit set)
module dec3to8 (
  input  logic       en,
  input  logic [2:0] sel,
  output logic [7:0] y
);

  always_comb begin
    y = 8'h00;
    if (en) y[sel] = 1'b1;
  end

endmodule

// File: rtl/proc_control_fsm_regn.sv
// regn: generic register with synchronous active-high reset and load enable.
//   clk : rising-edge clock
//   rst : synchronous reset to zero (priority over en)
//   en  : load d on the next rising edge
//   d   : input data
//   q   : registered data
module regn #(
  parameter int DATA_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/proc_control_fsm.sv
// proc_control_fsm: multi-cycle control unit for the simple processor.
// Latches each instruction word into IR and steps through T0..T3, driving
// the register file, A/G registers, ALU and bus multiplexer.
//
// Ports:
//   Clk      : rising-edge clock
//   Reset    : synchronous active-high reset (state <= T0, IR <= 0)
//   Run      : Din holds a valid word this cycle
//   Din      : instruction or immediate word
//   Ready    : in T0, will accept an opcode
//   NextWord : one-cycle request to advance the ROM program counter
//   IRin     : instruction register load strobe
//   Rin      : one-hot register write enables
//   Rout     : one-hot register bus drive
//   DINout   : drive Din onto the bus
//   Ain      : load A register
//   Gin      : load G register
//   Gout     : drive G onto the bus
//   AluOp    : 00 add, 01 sub, 10 and (nonzero only in T2)
//   Done     : instruction retires this cycle
//
// All control outputs are combinational decodes of state, IR and Run.
module proc_control_fsm
  import proc_defs::*;
#(
  parameter int NREG = 8
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Run,
  input  logic [IR_W-1:0] Din,
  output logic            Ready,
  output logic            NextWord,
  output logic            IRin,
  output logic [NREG-1:0] Rin,
  output logic [NREG-1:0] Rout,
  output logic            DINout,
  output logic            Ain,
  output logic            Gin,
  output logic            Gout,
  output logic [1:0]      AluOp,
  output logic            Done
);

  state_t            state;
  logic [IR_W-1:0]   ir;
  logic [OPC_W-1:0]  op;
  logic [REG_W-1:0]  rx;
  logic [REG_W-1:0]  ry;

  logic              rin_en;
  logic [REG_W-1:0]  rin_sel;
  logic              rout_en;
  logic [REG_W-1:0]  rout_sel;

  assign op = ir[9:6];
  assign rx = ir[5:3];
  assign ry = ir[2:0];

  // IR only loads on an accepted opcode, so Din changes after T0 cannot
  // disturb the instruction being sequenced.
  regn #(
    .DATA_W(IR_W)
  ) u_ir (
    .clk(Clk),
    .rst(Reset),
    .en (IRin),
    .d  (Din),
    .q  (ir)
  );

  dec3to8 u_rin_dec (
    .en (rin_en),
    .sel(rin_sel),
    .y  (Rin)
  );

  dec3to8 u_rout_dec (
    .en (rout_en),
    .sel(rout_sel),
    .y  (Rout)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= T0;
    end else begin
      case (state)
        T0: if (Run) state <= T1;
        T1: begin
          if (is_alu_op(op))                state <= T2;
          else if (op != OP_MVI || Run)     state <= T0;
        end
        T2: state <= T3;
        T3: state <= T0;
        default: state <= T0;
      endcase
    end
  end

  always_comb begin
    Ready    = 1'b0;
    NextWord = 1'b0;
    IRin     = 1'b0;
    DINout   = 1'b0;
    Ain      = 1'b0;
    Gin      = 1'b0;
    Gout     = 1'b0;
    AluOp    = ALU_ADD;
    Done     = 1'b0;
    rin_en   = 1'b0;
    rin_sel  = rx;
    rout_en  = 1'b0;
    rout_sel = ry;

    case (state)
      T0: begin
        Ready = 1'b1;
        if (Run) begin
          IRin     = 1'b1;
          NextWord = 1'b1;
        end
      end

      T1: begin
        case (op)
          OP_MV: begin
            rout_en  = 1'b1;
            rout_sel = ry;
            rin_en   = 1'b1;
            Done     = 1'b1;
          end
          OP_MVI: begin
            // Hold in T1 until the immediate word is presented.
            if (Run) begin
              DINout   = 1'b1;
              rin_en   = 1'b1;
              NextWord = 1'b1;
              Done     = 1'b1;
            end
          end
          OP_ADD, OP_SUB, OP_AND: begin
            rout_en  = 1'b1;
            rout_sel = rx;
            Ain      = 1'b1;
          end
          default: Done = 1'b1;
        endcase
      end

      T2: begin
        rout_en  = 1'b1;
        rout_sel = ry;
        Gin      = 1'b1;
        AluOp    = alu_op_of(op);
      end

      T3: begin
        Gout   = 1'b1;
        rin_en = 1'b1;
        Done   = 1'b1;
      end

      default: ;
    endcase
  end

endmodule

// File: tb/tb_proc_control_fsm.sv
module tb_proc_control_fsm;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Run = 1'b0;
  logic [9:0] Din = '0;
  logic       Ready, NextWord, IRin, DINout, Ain, Gin, Gout, Done;
  logic [7:0] Rin, Rout;
  logic [1:0] AluOp;

  proc_control_fsm #(.NREG(8)) dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Din(Din),
    .Ready(Ready), .NextWord(NextWord), .IRin(IRin),
    .Rin(Rin), .Rout(Rout), .DINout(DINout), .Ain(Ain),
    .Gin(Gin), .Gout(Gout), .AluOp(AluOp), .Done(Done)
  );

  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a queue of the output patterns an accepted instruction
  // will produce on its remaining cycles, plus a flag for an mvi awaiting
  // its immediate word. Empty queue and no pending mvi means "idle".
  typedef struct packed {
    logic [7:0] rin;
    logic [7:0] rout;
    logic       dinout;
    logic       ain;
    logic       gin;
    logic       gout;
    logic [1:0] aluop;
    logic       done;
    logic       nextword;
  } exp_t;

  exp_t       exp_q[$];
  logic       mvi_wait = 1'b0;
  logic [2:0] mvi_rx = '0;
  int         nw_cnt = 0;
  int         done_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] onehot(input logic [2:0] idx);
    onehot = 8'd1 << idx;
  endfunction

  task automatic plan(input logic [9:0] w);
    logic [3:0] op;
    logic [2:0] rx, ry;
    exp_t e;
    op = w[9:6]; rx = w[5:3]; ry = w[2:0];
    case (op)
      4'd0: begin
        e = '0; e.rout = onehot(ry); e.rin = onehot(rx); e.done = 1'b1;
        exp_q.push_back(e);
      end
      4'd1: begin
        mvi_wait = 1'b1; mvi_rx = rx;
      end
      4'd2, 4'd3, 4'd4: begin
        e = '0; e.rout = onehot(rx); e.ain = 1'b1; exp_q.push_back(e);
        e = '0; e.rout = onehot(ry); e.gin = 1'b1;
        e.aluop = (op == 4'd2) ? 2'b00 : (op == 4'd3) ? 2'b01 : 2'b10;
        exp_q.push_back(e);
        e = '0; e.gout = 1'b1; e.rin = onehot(rx); e.done = 1'b1; exp_q.push_back(e);
      end
      default: begin
        e = '0; e.done = 1'b1; exp_q.push_back(e);
      end
    endcase
  endtask

  // Apply one cycle of inputs, compare all outputs against the model,
  // then advance the model as the coming clock edge will.
  task automatic step(input logic run, input logic [9:0] din, input logic rst);
    exp_t e;
    logic ready_e, irin_e;
    @(negedge Clk);
    Run = run; Din = din; Reset = rst;
    #1;
    e = '0; ready_e = 1'b0; irin_e = 1'b0;
    if (exp_q.size() == 0 && !mvi_wait) begin
      ready_e = 1'b1;
      if (run) begin
        irin_e = 1'b1; e.nextword = 1'b1;
        plan(din);
      end
    end else if (mvi_wait) begin
      if (run) begin
        e.dinout = 1'b1; e.rin = onehot(mvi_rx); e.nextword = 1'b1; e.done = 1'b1;
        mvi_wait = 1'b0;
      end
    end else begin
      e = exp_q.pop_front();
    end
    chk("outs",
        {6'd0, Ready, NextWord, IRin, Rin, Rout, DINout, Ain, Gin, Gout, AluOp, Done},
        {6'd0, ready_e, e.nextword, irin_e, e.rin, e.rout, e.dinout, e.ain, e.gin,
         e.gout, e.aluop, e.done});
    if (NextWord) nw_cnt++;
    if (Done) done_cnt++;
    if (rst) begin
      exp_q.delete();
      mvi_wait = 1'b0;
    end
  endtask

  initial begin
    logic [3:0] op;
    // First edge brings the state out of its power-up value.
    Reset = 1'b1; Run = 1'b0;
    @(posedge Clk);

    // Reset then idle.
    step(1'b0, 10'h000, 1'b1);
    step(1'b0, 10'h000, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 10'h3ff, 1'b0);
      chk("idle_ready", Ready, 1);
      chk("idle_done", {NextWord, Done, Rin, Rout}, 0);
    end

    // mv R3 <- R5.
    step(1'b1, 10'b0000_011_101, 1'b0);
    step(1'b0, 10'h000, 1'b0);
    chk("mv_rout", Rout, 8'h20);
    chk("mv_rin", Rin, 8'h08);
    chk("mv_done", Done, 1);
    step(1'b0, 10'h000, 1'b0);
    chk("mv_ready", Ready, 1);

    // mvi R2 with two wait cycles.
    step(1'b1, 10'b0001_010_000, 1'b0);
    step(1'b0, 10'h000, 1'b0);
    chk("mvi_wait_ready", Ready, 0);
    step(1'b0, 10'h000, 1'b0);
    chk("mvi_wait_done", Done, 0);
    step(1'b1, 10'h155, 1'b0);
    chk("mvi_imm", {DINout, Rin, Done, NextWord}, {1'b1, 8'h04, 1'b1, 1'b1});

    // sub R1, R6.
    step(1'b1, 10'b0011_001_110, 1'b0);
    step(1'b1, 10'h3ff, 1'b0);
    chk("sub_t1", {Rout, Ain}, {8'h02, 1'b1});
    step(1'b1, 10'h3ff, 1'b0);
    chk("sub_t2", {Rout, Gin, AluOp}, {8'h40, 1'b1, 2'b01});
    step(1'b0, 10'h000, 1'b0);
    chk("sub_t3", {Gout, Rin, Done}, {1'b1, 8'h02, 1'b1});

    // Reset during T2 of add R0, R7.
    step(1'b1, 10'b0010_000_111, 1'b0);
    step(1'b0, 10'h000, 1'b0);
    step(1'b0, 10'h000, 1'b1);
    step(1'b0, 10'h000, 1'b0);
    chk("rst_mid_ready", Ready, 1);
    chk("rst_mid_quiet", {Done, Rin}, 0);

    // nop followed immediately by mv.
    nw_cnt = 0; done_cnt = 0;
    step(1'b1, 10'b1111_000_000, 1'b0);
    chk("b2b_c1_done", Done, 0);
    step(1'b1, 10'b0000_001_010, 1'b0);
    chk("b2b_c2_done", Done, 1);
    step(1'b1, 10'b0000_001_010, 1'b0);
    chk("b2b_c3_done", Done, 0);
    step(1'b0, 10'h000, 1'b0);
    chk("b2b_c4_done", Done, 1);
    chk("b2b_nextword", nw_cnt, 2);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      op = 4'($urandom_range(0, 6));
      if (op == 4'd6) op = 4'($urandom_range(5, 15));
      step($urandom_range(0, 2) != 0, {op, 6'($urandom)}, $urandom_range(0, 60) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
